// File: rtl/alu_pkg.sv
// alu_pkg: shared ctrl codes, FSM state type and op classification
// for the multi-cycle execute-stage ALU (alu_mc / alu_muldiv).
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_DIVU = 4'd4;
    localparam logic [3:0] ALU_REMU = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_XOR  = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_t;

    function automatic logic is_multicycle(input logic [3:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_DIVU) ||
               (ctrl == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: bit-serial shift-add multiplier and restoring unsigned
// divider. Ports: clk_i/rst_i, start/op/a/b in; busy/done/result out.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_END = (SHW+1)'(WIDTH);

    logic [SHW:0]     cnt_q;
    logic             run_q;
    logic [3:0]       op_q;
    // x: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // y: multiplier (MUL) or divisor (DIV)
    // acc: product (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] acc_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;

    assign trial = {acc_q, x_q[WIDTH-1]};
    assign diff  = trial - {1'b0, y_q};
    // With a zero divisor every step fits: quotient all ones and the
    // dividend ends up shifted whole into the remainder.
    assign fits  = (trial >= {1'b0, y_q});

    assign done   = run_q && (cnt_q == CNT_END);
    assign busy   = run_q;
    assign result = (op_q == ALU_DIVU) ? x_q : acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            op_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
            run_q <= 1'b1;
            op_q  <= op;
            x_q   <= a;
            y_q   <= b;
            acc_q <= '0;
        end else if (run_q) begin
            if (cnt_q == CNT_END) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (op_q == ALU_MUL) begin
                    if (y_q[0]) begin
                        acc_q <= acc_q + x_q;
                    end
                    x_q <= x_q << 1;
                    y_q <= y_q >> 1;
                end else begin
                    acc_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    x_q   <= {x_q[WIDTH-2:0], fits};
                end
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute ALU with valid/ready on both sides.
// Ports: clk_i, rst_i, in_valid_i/in_ready_o, src1_i, src2_i, ctrl_i,
// out_valid_o/out_ready_i, result_o, zero_o, overflow_o.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);

    alu_state_t       state_q;
    logic             accept;
    logic             mdu_start;
    logic             mdu_busy;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_res;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;

    assign in_ready_o = ((state_q == IDLE) && !mdu_busy) ||
                        ((state_q == DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign mdu_start  = accept && is_multicycle(ctrl_i);

    assign sum   = src1_i + src2_i;
    assign dif   = src1_i - src2_i;
    assign shamt = src2_i[SHW-1:0];

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        unique case (1'b1)
            (ctrl_i == ALU_AND):  sc_res = src1_i & src2_i;
            (ctrl_i == ALU_OR):   sc_res = src1_i | src2_i;
            (ctrl_i == ALU_ADD): begin
                sc_res = sum;
                sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                         (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            (ctrl_i == ALU_SUB): begin
                sc_res = dif;
                sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                         (dif[WIDTH-1] != src1_i[WIDTH-1]);
            end
            (ctrl_i == ALU_SLTU):
                sc_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            (ctrl_i == ALU_SLT):
                sc_res = {{(WIDTH-1){1'b0}},
                          ($signed(src1_i) < $signed(src2_i))};
            (ctrl_i == ALU_SLL):  sc_res = src1_i << shamt;
            (ctrl_i == ALU_SRL):  sc_res = src1_i >> shamt;
            (ctrl_i == ALU_SRA):
                sc_res = WIDTH'($signed(src1_i) >>> shamt);
            (ctrl_i == ALU_NOR):  sc_res = ~(src1_i | src2_i);
            (ctrl_i == ALU_XOR):  sc_res = src1_i ^ src2_i;
            default:              sc_res = '0;
        endcase
    end

    alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (mdu_start),
        .op     (ctrl_i),
        .a      (src1_i),
        .b      (src2_i),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_res)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            zero_o      <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_multicycle(ctrl_i)) begin
                            state_q     <= BUSY;
                            out_valid_o <= 1'b0;
                        end else begin
                            state_q     <= DONE;
                            out_valid_o <= 1'b1;
                            result_o    <= sc_res;
                            zero_o      <= (sc_res == '0);
                            overflow_o  <= sc_ovf;
                        end
                    end else if ((state_q == DONE) && out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mdu_done) begin
                        state_q     <= DONE;
                        out_valid_o <= 1'b1;
                        result_o    <= mdu_res;
                        zero_o      <= (mdu_res == '0);
                        overflow_o  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
